// File: rtl/driver_outputs_packer_pkg.sv
// Shared definitions for the weight driver and the output packer: default widths,
// the lane count, the lane-index type and the lane insert / zero-pad helpers.
package driver_outputs_packer_pkg;

  localparam int unsigned IoDataWidth = 8;
  localparam int unsigned MemBw       = 128;
  localparam int unsigned Lanes       = MemBw / IoDataWidth;
  localparam int unsigned LaneIdxW    = (Lanes > 1) ? $clog2(Lanes) : 1;

  typedef logic [LaneIdxW-1:0] lane_idx_t;

  // Writes elem into lane k (lane 0 is the MSB lane). With pad set, every lane after k
  // is cleared so a word closed early carries no stale data.
  function automatic logic [MemBw-1:0] lane_insert(input logic [MemBw-1:0]       word,
                                                   input logic [IoDataWidth-1:0] elem,
                                                   input lane_idx_t              k,
                                                   input logic                   pad);
    logic [MemBw-1:0] res;
    res = word;
    for (int unsigned l = 0; l < Lanes; l++) begin
      if (lane_idx_t'(l) == k) begin
        res[(Lanes-1-l)*IoDataWidth +: IoDataWidth] = elem;
      end else if (pad && (lane_idx_t'(l) > k)) begin
        res[(Lanes-1-l)*IoDataWidth +: IoDataWidth] = '0;
      end
    end
    return res;
  endfunction

  // One bit per populated lane, lane 0 at the MSB: lanes 0..k set.
  function automatic logic [Lanes-1:0] lane_mask(input lane_idx_t k);
    logic [Lanes-1:0] m;
    m = '0;
    for (int unsigned l = 0; l < Lanes; l++) begin
      m[Lanes-1-l] = (lane_idx_t'(l) <= k);
    end
    return m;
  endfunction

endpackage

// File: rtl/driver_outputs_packer.sv
// Packs a stream of IO_DATA_WIDTH-bit elements MSB-lane-first into MEM_BW-bit words.
// An element flagged in_last closes the word early; unused lanes are zero.
// Optional macro DRIVER_OUTPUTS_BYTE_MASK_EN adds out_mask with one bit per populated lane.
module driver_outputs_packer
  import driver_outputs_packer_pkg::*;
#(
  parameter int unsigned IO_DATA_WIDTH = IoDataWidth,
  parameter int unsigned MEM_BW        = MemBw
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic [IO_DATA_WIDTH-1:0] in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [MEM_BW-1:0]        out_data,
  output logic                     out_valid,
`ifdef DRIVER_OUTPUTS_BYTE_MASK_EN
  output logic [MEM_BW/IO_DATA_WIDTH-1:0] out_mask,
`endif
  input  logic                     out_ready
);

  localparam int unsigned LANES = MEM_BW / IO_DATA_WIDTH;

  logic [MEM_BW-1:0] asm_q, asm_d;
  lane_idx_t         cnt_q, cnt_d;
  logic [MEM_BW-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              out_free, closing, accept;
  logic [MEM_BW-1:0] merged;

  // Handshake terms; in_ready deliberately does not look at in_valid.
  always_comb begin
    out_free = !out_valid_q || out_ready;
    closing  = (cnt_q == lane_idx_t'(LANES - 1)) || in_last;
    in_ready = !closing || out_free;
    accept   = in_valid && in_ready;
  end

  // Next-state: fill lanes, hand a closed word to the output register.
  always_comb begin
    asm_d       = asm_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q && !out_ready;
    merged      = lane_insert(asm_q, in_data, cnt_q, closing);
    if (accept) begin
      if (closing) begin
        out_d       = merged;
        out_valid_d = 1'b1;
        asm_d       = '0;
        cnt_d       = '0;
      end else begin
        asm_d = merged;
        cnt_d = cnt_q + lane_idx_t'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      asm_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_q;
  assign out_valid = out_valid_q;

`ifdef DRIVER_OUTPUTS_BYTE_MASK_EN
  logic [LANES-1:0] mask_q;

  // Lane-populated mask, loaded with the word it describes.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      mask_q <= '0;
    end else if (accept && closing) begin
      mask_q <= lane_mask(cnt_q);
    end
  end

  assign out_mask = mask_q;
`endif

endmodule
